// File: rtl/conv_job_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : conv_job_sequencer
// Purpose  : Walks the 3x3 binary convolution engine through a list of
//            kernels: per kernel it presents the weight/output addresses,
//            pulses eng_run, then waits for eng_busy to rise and fall.
//            A watchdog aborts a stuck kernel and raises a sticky seq_err.
// Options  : SEQ_PERF_CNT_EN adds the 32-bit seq_cycles busy-cycle counter.
// Revision : 1.0 - initial release
// ============================================================================
module conv_job_sequencer #(
    parameter int ADDR_W = 12,
    parameter int KCNT_W = 4,
    parameter int TMO_W  = 16
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              seq_start,
    input  logic [KCNT_W-1:0] seq_kernel_cnt,
    input  logic [ADDR_W-1:0] seq_wbase,
    input  logic [ADDR_W-1:0] seq_obase,
    input  logic [ADDR_W-1:0] seq_ostride,
    output logic              seq_busy,
    output logic              seq_done,
    output logic              seq_err,
    output logic [KCNT_W-1:0] seq_kidx,
    output logic              eng_run,
    input  logic              eng_busy,
    output logic [ADDR_W-1:0] eng_waddr,
    output logic [ADDR_W-1:0] eng_obase
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [31:0]       seq_cycles
`endif
);

    // One-hot with an all-zero IDLE, so every register resets to zero and
    // each decoded output is a single flop bit.
    typedef enum logic [4:0] {
        ST_IDLE   = 5'b00000,
        ST_LAUNCH = 5'b00001,
        ST_ACK    = 5'b00010,
        ST_WAIT   = 5'b00100,
        ST_NEXT   = 5'b01000,
        ST_DONE   = 5'b10000
    } state_t;

    state_t              state_q,  state_d;
    logic [KCNT_W-1:0]   kcnt_q,   kcnt_d;
    logic [ADDR_W-1:0]   stride_q, stride_d;
    logic [KCNT_W-1:0]   kidx_q,   kidx_d;
    logic [ADDR_W-1:0]   waddr_q,  waddr_d;
    logic [ADDR_W-1:0]   obase_q,  obase_d;
    logic                err_q,    err_d;
    logic [TMO_W-1:0]    wd_q,     wd_d;

    logic                start_accept;
    logic [TMO_W-1:0]    wd_inc;
    logic                wd_expire;

    // A start is honoured only from IDLE and only while the engine is quiet.
    assign start_accept = (state_q == ST_IDLE) && seq_start && !eng_busy;

    // The watchdog fires on the cycle its count would reach all-ones, giving
    // 2**TMO_W-1 cycles in ACK or WAIT before the abort.
    assign wd_inc    = wd_q + 1'b1;
    assign wd_expire = (wd_inc == {TMO_W{1'b1}});

    // Next-state and datapath update for the job sequencer.
    always_comb begin
        state_d  = state_q;
        kcnt_d   = kcnt_q;
        stride_d = stride_q;
        kidx_d   = kidx_q;
        waddr_d  = waddr_q;
        obase_d  = obase_q;
        err_d    = err_q;
        wd_d     = wd_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start_accept) begin
                    kcnt_d   = seq_kernel_cnt;
                    stride_d = seq_ostride;
                    err_d    = 1'b0;
                    kidx_d   = '0;
                    waddr_d  = seq_wbase;
                    obase_d  = seq_obase;
                    state_d  = (seq_kernel_cnt == '0) ? ST_DONE : ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                wd_d    = '0;
                state_d = ST_ACK;
            end
            ST_ACK: begin
                if (eng_busy) begin
                    wd_d    = '0;
                    state_d = ST_WAIT;
                end else if (wd_expire) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    wd_d    = wd_inc;
                end
            end
            ST_WAIT: begin
                if (!eng_busy) begin
                    state_d = ST_NEXT;
                end else if (wd_expire) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    wd_d    = wd_inc;
                end
            end
            ST_NEXT: begin
                kidx_d  = kidx_q + 1'b1;
                waddr_d = waddr_q + 1'b1;
                obase_d = obase_q + stride_q;
                state_d = (kidx_d < kcnt_q) ? ST_LAUNCH : ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q  <= ST_IDLE;
            kcnt_q   <= '0;
            stride_q <= '0;
            kidx_q   <= '0;
            waddr_q  <= '0;
            obase_q  <= '0;
            err_q    <= 1'b0;
            wd_q     <= '0;
        end else begin
            state_q  <= state_d;
            kcnt_q   <= kcnt_d;
            stride_q <= stride_d;
            kidx_q   <= kidx_d;
            waddr_q  <= waddr_d;
            obase_q  <= obase_d;
            err_q    <= err_d;
            wd_q     <= wd_d;
        end
    end

    assign seq_busy  = |state_q;
    assign eng_run   = state_q[0];
    assign seq_done  = state_q[4];
    assign seq_err   = err_q;
    assign seq_kidx  = kidx_q;
    assign eng_waddr = waddr_q;
    assign eng_obase = obase_q;

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] cyc_q, cyc_d;

    // Busy-cycle counter: cleared on an accepted start, saturating, held in IDLE.
    always_comb begin
        cyc_d = cyc_q;
        if (start_accept) begin
            cyc_d = '0;
        end else if (seq_busy && (cyc_q != 32'hFFFF_FFFF)) begin
            cyc_d = cyc_q + 32'd1;
        end
    end

    // Busy-cycle counter register.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_d;
        end
    end

    assign seq_cycles = cyc_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_conv_job_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_conv_job_sequencer
// Purpose  : Directed plus randomized bench for conv_job_sequencer with a
//            behavioural engine model and per-kernel address reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_job_sequencer;

    localparam int ADDR_W  = 12;
    localparam int KCNT_W  = 4;
    localparam int TMO_W   = 5;
    localparam int AMASK   = (1 << ADDR_W) - 1;
    localparam int KMASK   = (1 << KCNT_W) - 1;
    localparam int TMO_CYC = 1 << TMO_W;

    logic              clk     = 1'b0;
    logic              reset_b = 1'b0;
    logic              seq_start = 1'b0;
    logic [KCNT_W-1:0] seq_kernel_cnt = '0;
    logic [ADDR_W-1:0] seq_wbase = '0;
    logic [ADDR_W-1:0] seq_obase = '0;
    logic [ADDR_W-1:0] seq_ostride = '0;
    logic              seq_busy, seq_done, seq_err, eng_run;
    logic [KCNT_W-1:0] seq_kidx;
    logic [ADDR_W-1:0] eng_waddr, eng_obase;
    logic              eng_busy;
`ifdef SEQ_PERF_CNT_EN
    logic [31:0]       seq_cycles;
`endif

    // engine model controls
    int   ack_dly    = 0;
    int   busy_len   = 1;
    bit   eng_hang   = 1'b0;
    logic force_busy = 1'b0;
    logic model_busy = 1'b0;
    bit   pending    = 1'b0;
    int   dly_cnt    = 0;
    int   len_cnt    = 0;

    // observation
    int run_w[$];
    int run_o[$];
    int run_k[$];
    int done_cnt  = 0;
    int busy_cyc  = 0;

    int checks = 0;
    int errors = 0;

    assign eng_busy = model_busy | force_busy;

    always #5 clk = ~clk;

    conv_job_sequencer #(
        .ADDR_W (ADDR_W),
        .KCNT_W (KCNT_W),
        .TMO_W  (TMO_W)
    ) dut (
        .clk            (clk),
        .reset_b        (reset_b),
        .seq_start      (seq_start),
        .seq_kernel_cnt (seq_kernel_cnt),
        .seq_wbase      (seq_wbase),
        .seq_obase      (seq_obase),
        .seq_ostride    (seq_ostride),
        .seq_busy       (seq_busy),
        .seq_done       (seq_done),
        .seq_err        (seq_err),
        .seq_kidx       (seq_kidx),
        .eng_run        (eng_run),
        .eng_busy       (eng_busy),
        .eng_waddr      (eng_waddr),
        .eng_obase      (eng_obase)
`ifdef SEQ_PERF_CNT_EN
        ,
        .seq_cycles     (seq_cycles)
`endif
    );

    // Engine model: after a run pulse, wait ack_dly cycles, then busy for busy_len cycles.
    always @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            model_busy <= 1'b0;
            pending    <= 1'b0;
            dly_cnt    <= 0;
            len_cnt    <= 0;
        end else if (eng_run && !eng_hang) begin
            pending <= 1'b1;
            dly_cnt <= ack_dly;
            len_cnt <= busy_len;
        end else if (pending) begin
            if (dly_cnt == 0) begin
                pending    <= 1'b0;
                model_busy <= 1'b1;
            end else begin
                dly_cnt <= dly_cnt - 1;
            end
        end else if (model_busy) begin
            if (len_cnt <= 1) model_busy <= 1'b0;
            else              len_cnt <= len_cnt - 1;
        end
    end

    // Monitor: log every run pulse with its addresses, count done pulses and busy cycles.
    always @(posedge clk) begin
        if (reset_b) begin
            if (eng_run) begin
                run_w.push_back(int'(eng_waddr));
                run_o.push_back(int'(eng_obase));
                run_k.push_back(int'(seq_kidx));
            end
            if (seq_done) done_cnt = done_cnt + 1;
            if (seq_busy) busy_cyc = busy_cyc + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_cfg(input int cnt, input int wb, input int ob, input int st);
        seq_kernel_cnt = KCNT_W'(cnt);
        seq_wbase      = ADDR_W'(wb);
        seq_obase      = ADDR_W'(ob);
        seq_ostride    = ADDR_W'(st);
    endtask

    // Wait (bounded) for a new seq_done pulse; scrambles config and start meanwhile.
    task automatic wait_done(input int db, input bit scramble, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            if (done_cnt != db) begin
                seen = 1'b1;
            end else begin
                if (scramble) begin
                    drive_cfg($urandom_range(0, KMASK), $urandom_range(0, AMASK),
                              $urandom_range(0, AMASK), $urandom_range(0, AMASK));
                    seq_start = ($urandom_range(0, 5) == 0);
                end
                @(negedge clk);
            end
        end
        seq_start = 1'b0;
    endtask

    // One complete job with a well-behaved engine, checked against the kernel list rule.
    task automatic run_job(input int cnt, input int wb, input int ob, input int st,
                           input int ad, input int bl);
        int  rb, db, bb;
        bit  seen;
        ack_dly  = ad;
        busy_len = bl;
        eng_hang = 1'b0;
        drive_cfg(cnt, wb, ob, st);
        rb = run_w.size();
        db = done_cnt;
        bb = busy_cyc;
        seq_start = 1'b1;
        @(negedge clk);
        seq_start = 1'b0;
        check("busy_after_start", seq_busy, 1);
        check("err_cleared_on_start", seq_err, 0);
        if (cnt == 0) check("zero_cnt_done", seq_done, 1);
        else          check("first_run_latency", eng_run, 1);
        wait_done(db, 1'b1, seen);
        check("done_seen", seen, 1);
        check("done_count", done_cnt - db, 1);
        check("busy_low_after_done", seq_busy, 0);
        check("done_is_pulse", seq_done, 0);
        check("err_after_job", seq_err, 0);
        check("run_count", run_w.size() - rb, cnt);
        if (run_w.size() - rb == cnt) begin
            for (int k = 0; k < cnt; k++) begin
                check("kernel_waddr", run_w[rb+k], (wb + k) & AMASK);
                check("kernel_obase", run_o[rb+k], (ob + k * st) & AMASK);
                check("kernel_kidx",  run_k[rb+k], k);
            end
        end
        check("final_kidx",  seq_kidx,  cnt & KMASK);
        check("final_waddr", eng_waddr, (wb + cnt) & AMASK);
        check("final_obase", eng_obase, (ob + cnt * st) & AMASK);
`ifdef SEQ_PERF_CNT_EN
        check("perf_cycles", seq_cycles, busy_cyc - bb);
        repeat (3) @(negedge clk);
        check("perf_hold", seq_cycles, busy_cyc - bb);
`endif
        @(negedge clk);
    endtask

    initial begin : main
        int  n, rb, db, wb, ob;
        bit  seen;

        // reset state
        @(negedge clk);
        check("reset_outputs",
              {seq_busy, seq_done, seq_err, seq_kidx, eng_run, eng_waddr, eng_obase}, 0);
        @(negedge clk);
        reset_b = 1'b1;
        @(negedge clk);

        // basic 3-kernel job
        run_job(3, 1, 0, 16, 2, 20);

        // zero kernel count: done one cycle after start, busy one cycle
        run_job(0, 123, 456, 7, 0, 1);

        // engine never answers: ACK watchdog
        eng_hang = 1'b1;
        wb = $urandom_range(0, AMASK);
        ob = $urandom_range(0, AMASK);
        drive_cfg(2, wb, ob, 33);
        rb = run_w.size();
        seq_start = 1'b1;
        @(negedge clk);
        seq_start = 1'b0;
        check("tmo_run", eng_run, 1);
        n = 0;
        while (seq_done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("tmo_latency", n, TMO_CYC);
        check("tmo_err", seq_err, 1);
        @(negedge clk);
        check("tmo_err_sticky", seq_err, 1);
        check("tmo_busy_low", seq_busy, 0);
        check("tmo_waddr_hold", eng_waddr, wb);
        check("tmo_obase_hold", eng_obase, ob);
        check("tmo_kidx_hold", seq_kidx, 0);
        check("tmo_single_run", run_w.size() - rb, 1);
        eng_hang = 1'b0;

        // engine stuck busy: WAIT watchdog, then a start while engine busy is ignored
        ack_dly  = 1;
        busy_len = 3 * TMO_CYC;
        drive_cfg(3, 10, 20, 30);
        rb = run_w.size();
        db = done_cnt;
        seq_start = 1'b1;
        @(negedge clk);
        seq_start = 1'b0;
        wait_done(db, 1'b0, seen);
        check("wait_tmo_done", seen, 1);
        check("wait_tmo_err", seq_err, 1);
        check("wait_tmo_kidx", seq_kidx, 0);
        check("wait_tmo_runs", run_w.size() - rb, 1);
        seq_start = 1'b1;
        @(negedge clk);
        seq_start = 1'b0;
        check("start_ignored_eng_busy", seq_busy, 0);
        check("no_run_eng_busy", eng_run, 0);
        n = 0;
        while (eng_busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("engine_idle_bound", eng_busy, 0);
        run_job(2, 77, 900, 5, 1, 4);

        // start while engine busy (forced) is ignored
        force_busy = 1'b1;
        seq_start  = 1'b1;
        @(negedge clk);
        seq_start  = 1'b0;
        check("forced_busy_ignored", seq_busy, 0);
        @(negedge clk);
        check("forced_busy_no_run", eng_run, 0);
        force_busy = 1'b0;
        @(negedge clk);

        // async reset while in WAIT on kernel 1
        ack_dly  = 2;
        busy_len = 20;
        drive_cfg(3, 300, 400, 50);
        rb = run_w.size();
        db = done_cnt;
        seq_start = 1'b1;
        @(negedge clk);
        seq_start = 1'b0;
        n = 0;
        while (!(seq_kidx == 1 && eng_busy) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("reach_kernel1_bound", seq_kidx, 1);
        repeat (2) @(negedge clk);
        reset_b = 1'b0;
        #1;
        check("async_reset_outputs",
              {seq_busy, seq_done, seq_err, seq_kidx, eng_run, eng_waddr, eng_obase}, 0);
        check("reset_runs_before", run_w.size() - rb, 2);
        @(negedge clk);
        @(negedge clk);
        reset_b = 1'b1;
        check("no_done_on_reset", done_cnt - db, 0);
        @(negedge clk);
        run_job(2, 300, 400, 50, 0, 3);

        // address wrap-around
        run_job(4, AMASK - 1, AMASK - 50, 100, 0, 1);

        // randomized jobs
        for (int j = 0; j < 8; j++) begin
            run_job($urandom_range(1, 4), $urandom_range(0, AMASK), $urandom_range(0, AMASK),
                    $urandom_range(0, AMASK), $urandom_range(0, 4), $urandom_range(1, 20));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
